// File: rtl/memoria_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, FSM states
// and the byte-lane helpers used by the memory and its load aligner.
package memoria_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Byte lanes touched by an access; zero for the illegal size.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lane;
            SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: bad_align = 1'b0;
            SZ_HALF: bad_align = lane[0];
            SZ_WORD: bad_align = (lane != 2'b00);
            default: bad_align = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memoria_alinea.sv
// Load aligner: moves the addressed byte/half of a raw memory word down to
// bit 0 and sign- or zero-extends it. Purely combinational.
module memoria_alinea
    import memoria_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic        sgn;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned and infer a latch.
        data    = '0;
        sgn     = 1'b0;
        shifted = '0;
        case (size)
            SZ_BYTE: begin
                shifted = raw >> {lane, 3'b000};
                sgn     = shifted[7] & ~uns;
                data    = {{24{sgn}}, shifted[7:0]};
            end
            SZ_HALF: begin
                shifted = raw >> {lane[1], 4'b0000};
                sgn     = shifted[15] & ~uns;
                data    = {{16{sgn}}, shifted[15:0]};
            end
            SZ_WORD: data = raw;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/memoria_datos.sv
// MEM-stage data memory: byte/half/word accesses behind a valid/ready
// handshake, WAIT_CYCLES wait states, one request in flight, error response.
module memoria_datos
    import memoria_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    req_t              in_req, held, cur;
    logic [31:0]       mem [DEPTH];

    logic              accept, enter_resp, acc_err, in_range;
    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [3:0]        be;
    logic [31:0]       wdata_lane, rd_word, ld_data;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign in_req    = '{we: req_we, size: req_size, uns: req_unsigned,
                         addr: req_addr, wdata: req_wdata};

    // With no wait states the access happens on the accept edge itself, so
    // the operands come straight from the request port instead of the latch.
    assign cur        = (state == ST_IDLE) ? in_req : held;
    assign enter_resp = (WAIT_CYCLES == 0) ? accept : (state == ST_WAIT && cnt == '0);

    assign word_idx   = cur.addr[ADDR_W-1:2];
    assign in_range   = word_idx < (ADDR_W-2)'(DEPTH);
    assign mem_idx    = word_idx[IDX_W-1:0];
    assign acc_err    = bad_align(cur.size, cur.addr[1:0]) || !in_range;
    assign be         = byte_en(cur.size, cur.addr[1:0]);
    assign wdata_lane = cur.wdata << {cur.addr[1:0], 3'b000};
    assign rd_word    = mem[mem_idx];

    memoria_alinea u_alinea (
        .raw  (rd_word),
        .lane (cur.addr[1:0]),
        .size (cur.size),
        .uns  (cur.uns),
        .data (ld_data)
    );

    // NOTE: the data array is deliberately left without a reset; only the
    // control state is cleared, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur.we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[mem_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            held       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= enter_resp;
            resp_err   <= enter_resp && acc_err;
            resp_rdata <= (enter_resp && !cur.we && !acc_err) ? ld_data : '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        held  <= in_req;
                        cnt   <= CNT_INIT;
                        state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_RESP;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_datos.sv
// Directed bench for memoria_datos: table of single accesses on a 2-wait-state
// instance, plus reset-abort and back-to-back sequences on a 0-wait instance.
module tb_memoria_datos;
    import memoria_pkg::*;

    localparam int W = 2;

    logic        clk;
    logic        rst, req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_err;

    logic        z_rst, z_valid, z_ready, z_we, z_uns;
    logic [1:0]  z_size;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_resp_valid, z_err;

    int checks = 0;
    int errors = 0;

    memoria_datos #(.ADDR_W(32), .DEPTH(512), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    memoria_datos #(.ADDR_W(32), .DEPTH(512), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(z_rst), .req_valid(z_valid), .req_ready(z_ready),
        .req_we(z_we), .req_size(z_size), .req_unsigned(z_uns),
        .req_addr(z_addr), .req_wdata(z_wdata), .resp_valid(z_resp_valid),
        .resp_rdata(z_rdata), .resp_err(z_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v = '{we: we, size: size, uns: uns, addr: addr, wdata: wdata,
              exp_rdata: exp_rdata, exp_err: exp_err};
        vecs.push_back(v);
    endtask

    // One request on the 2-wait instance: handshake, latency, response, idle.
    task automatic run_req(input vec_t v, input string name);
        int n;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " accept"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " latency"}, seen ? n : 0, W + 1);
        check({name, " rdata"}, resp_rdata, v.exp_rdata);
        check({name, " err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        check({name, " pulse end"}, {29'd0, resp_valid, resp_err, req_ready}, 32'd1);
        check({name, " rdata idle"}, resp_rdata, 32'd0);
    endtask

    // Store to 0x10 aborted by a reset asserted n_neg cycles after accept.
    task automatic rst_abort(input int n_neg, input string name);
        int resp_seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        resp_seen = 0;
        for (int i = 0; i < n_neg; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
            if (i == 0) check({name, " ready low in wait"}, {31'd0, req_ready}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check({name, " ready after rst"}, {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check({name, " no response"}, resp_seen, 0);
        run_req('{we: 1'b0, size: SZ_WORD, uns: 1'b0, addr: 32'h10, wdata: 32'h0,
                  exp_rdata: 32'hDEAD80EF, exp_err: 1'b0}, {name, " reload"});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        z_rst = 1'b1; z_valid = 1'b0; z_we = 1'b0; z_size = SZ_WORD;
        z_uns = 1'b0; z_addr = '0; z_wdata = '0;

        //   we    size     uns   addr          wdata         exp_rdata     err
        add(1'b1, SZ_WORD, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0);
        add(1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b1, SZ_BYTE, 1'b0, 32'h11,       32'h00000080, 32'h0,        1'b0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h11,       32'h0,        32'hFFFFFF80, 1'b0);
        add(1'b0, SZ_BYTE, 1'b1, 32'h11,       32'h0,        32'h00000080, 1'b0);
        add(1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'hDEAD80EF, 1'b0);
        add(1'b0, SZ_HALF, 1'b0, 32'h10,       32'h0,        32'hFFFF80EF, 1'b0);
        add(1'b0, SZ_HALF, 1'b1, 32'h12,       32'h0,        32'h0000DEAD, 1'b0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h13,       32'h0,        32'hFFFFFFDE, 1'b0);
        add(1'b1, SZ_WORD, 1'b0, 32'h20,       32'h5555AAAA, 32'h0,        1'b0);
        add(1'b1, SZ_HALF, 1'b0, 32'h22,       32'hFFFF1234, 32'h0,        1'b0);
        add(1'b0, SZ_HALF, 1'b0, 32'h22,       32'h0,        32'h00001234, 1'b0);
        add(1'b0, SZ_WORD, 1'b0, 32'h20,       32'h0,        32'h1234AAAA, 1'b0);
        add(1'b0, SZ_HALF, 1'b0, 32'h21,       32'h0,        32'h0,        1'b1);
        add(1'b1, SZ_WORD, 1'b0, 32'h12,       32'h11111111, 32'h0,        1'b1);
        add(1'b1, SZ_BAD,  1'b0, 32'h10,       32'h22222222, 32'h0,        1'b1);
        add(1'b0, SZ_BAD,  1'b0, 32'h10,       32'h0,        32'h0,        1'b1);
        add(1'b0, SZ_WORD, 1'b0, 32'h800,      32'h0,        32'h0,        1'b1);
        add(1'b1, SZ_WORD, 1'b0, 32'h800,      32'h33333333, 32'h0,        1'b1);
        add(1'b1, SZ_BYTE, 1'b0, 32'h801,      32'h44,       32'h0,        1'b1);
        add(1'b0, SZ_WORD, 1'b0, 32'h80000010, 32'h0,        32'h0,        1'b1);
        add(1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'hDEAD80EF, 1'b0);
        add(1'b0, SZ_WORD, 1'b0, 32'h20,       32'h0,        32'h1234AAAA, 1'b0);
        add(1'b1, SZ_WORD, 1'b0, 32'h7FC,      32'hCAFEF00D, 32'h0,        1'b0);
        add(1'b0, SZ_WORD, 1'b0, 32'h7FC,      32'h0,        32'hCAFEF00D, 1'b0);
        add(1'b0, SZ_BYTE, 1'b1, 32'h7FF,      32'h0,        32'h000000CA, 1'b0);
        add(1'b0, SZ_HALF, 1'b0, 32'h7FC,      32'h0,        32'hFFFFF00D, 1'b0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h7FE,      32'h0,        32'hFFFFFFFE, 1'b0);

        repeat (3) @(negedge clk);
        check("reset ready", {31'd0, req_ready}, 32'd0);
        check("reset resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset ready w0", {31'd0, z_ready}, 32'd0);
        rst = 1'b0;
        #1 check("ready after release", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

        rst_abort(1, "rst in wait");
        rst_abort(2, "rst on write edge");

        // Back-to-back on the zero-wait instance with req_valid held high.
        @(negedge clk);
        z_valid = 1'b1; z_we = 1'b1; z_size = SZ_WORD; z_addr = 32'h40; z_wdata = 32'h600DCAFE;
        @(negedge clk);
        z_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("b2b ready c%0d", i), {31'd0, z_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b resp c%0d", i), {31'd0, z_resp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        z_valid = 1'b0;
        @(negedge clk);
        z_we = 1'b0; z_valid = 1'b1;
        @(posedge clk);
        #1 z_valid = 1'b0;
        @(negedge clk);
        check("w0 load valid", {31'd0, z_resp_valid}, 32'd1);
        check("w0 load rdata", z_rdata, 32'h600DCAFE);
        check("w0 load err", {31'd0, z_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
